imm_decode_stage: RTL
=====================

# imm_decode_stage

Registered, parametrised immediate-decode pipeline stage between fetch and the register-read/execute stage. Accepts one 32-bit instruction plus PC per cycle over a valid/ready handshake. Produces the sign/zero-extended immediate, an immediate-class tag and an illegal-encoding flag one cycle later. A two-entry skid buffer breaks the combinational ready path, and the stage supports pipeline flush and XLEN of 32 or 64, including shamt, CSR and zimm immediates.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all buffered beats; synchronous to clk.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat; registered.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_instr  out  32  instruction passthrough.
- out_pc  out  XLEN  PC passthrough.
- out_imm  out  XLEN  decoded immediate.
- out_imm_type  out  imm_type_t  immediate class.
- out_illegal  out  1  unsupported opcode, or instr[1:0] != 2'b11.

## Operation
- Decode keys on opcode = instr[6:0] (riscv_pkg opcode_t) and funct3 = instr[14:12].
- I-type: LOAD, JALR, and I_TYPE with funct3 not in {001, 101}. imm = sext(instr[31:20]). Class IMM_I.
- Shifts: I_TYPE with funct3 001 or 101. Class IMM_SHAMT.
  - XLEN=64: imm = zext(instr[25:20]).
  - XLEN=32: imm = zext(instr[24:20]).
- S-type, STORE: imm = sext({instr[31:25], instr[11:7]}). Class IMM_S.
- B-type, BRANCH: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}). Class IMM_B.
- J-type, JAL: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}). Class IMM_J.
- U-type, LUI and AUIPC: imm = sext({instr[31:12], 12'b0}). Sign-extends to 64 bits when XLEN=64. Class IMM_U.
- SYSTEM with funct3[2]=1: imm = zext(instr[19:15]). Class IMM_Z.
- SYSTEM with funct3[2]=0: imm = zext(instr[31:20]). Class IMM_CSR.
- R_TYPE, FENCE: imm = 0, class IMM_NONE, legal.
- Any other opcode, or instr[1:0] != 2'b11: imm = 0, class IMM_NONE, out_illegal = 1. The beat is still passed downstream.

## Timing
- Reset (async assert on rst_n low):
  - out_valid = 0, in_ready = 1.
  - out_instr, out_pc, out_imm = 0; out_imm_type = IMM_NONE; out_illegal = 0.
  - Reset mid-stream drops all buffered beats immediately.
- Storage: main register (drives outputs) plus one skid register. Decode result is registered, not computed on outputs.
- Latency: a beat accepted at edge N is presented on out_* after edge N.
- Throughput: 1 beat/cycle while out_ready = 1.
- in_ready = !skid_valid.
- Per-edge behaviour (main_free = !out_valid || out_ready):
  - Accept with main_free: load the accepted beat into main.
  - Accept with main not free: load the beat into skid; in_ready is 0 from the next cycle.
  - Skid occupied and main_free: move skid into main; in_ready returns to 1 the next cycle.
- Ordering: strict FIFO; no drop, no duplication.
- While out_valid && !out_ready, all out_* payload is held stable.
- flush:
  - At the edge, clears main and skid; in_valid in that cycle is ignored.
  - Next cycle: out_valid = 0, in_ready = 1.
  - flush has priority over every handshake in the same cycle.
- Downstream sample and flush in the same cycle: the beat counts as consumed; nothing is reissued.

## Structure
- riscv_pkg additions:
  - imm_type_t enum {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT, IMM_Z, IMM_CSR}.
  - Opcode values in opcode_t: OP_R_TYPE, OP_SYSTEM, OP_FENCE.
- Sub-module imm_extract: purely combinational, parametrised by XLEN. Maps instr to {imm, imm_type, illegal}.
- imm_decode_stage owns the skid/handshake logic.

## Test plan
- XLEN=32, in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1:
  - Next cycle: out_imm=0xFFFFFFFF, IMM_I, out_illegal=0.
- XLEN=32, 0xFFDFF06F (jal x0,-4):
  - out_imm=0xFFFFFFFC, IMM_J.
  - out_pc equals in_pc.
- XLEN=64, 0x800002B7 (lui x5,0x80000):
  - out_imm=0xFFFFFFFF80000000, IMM_U.
- XLEN=64, 0x43F0D093 (srai x1,x1,63):
  - out_imm=0x3F, IMM_SHAMT.
- 0x3002D073 (csrrwi x0,0x300,5):
  - out_imm=5, IMM_Z.
- 0x0000000B:
  - out_illegal=1, IMM_NONE, out_imm=0.
- Backpressure: four back-to-back beats, out_ready=0 for cycles 2-3:
  - in_ready falls one cycle after the skid fills.
  - All four beats emerge in order, each exactly once.
- Flush and reset:
  - Flush with main and skid both full: next cycle out_valid=0, in_ready=1.
  - rst_n pulsed low mid-stream: out_valid=0 without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: base opcodes and the immediate classes
// produced by the immediate-decode stage.
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_I_TYPE = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_R_TYPE = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [3:0] {
    IMM_NONE  = 4'd0,
    IMM_I     = 4'd1,
    IMM_S     = 4'd2,
    IMM_B     = 4'd3,
    IMM_J     = 4'd4,
    IMM_U     = 4'd5,
    IMM_SHAMT = 4'd6,
    IMM_Z     = 4'd7,
    IMM_CSR   = 4'd8
  } imm_type_t;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream/downstream handshake bundle of the immediate-decode stage.
// The stage itself takes the slave view; the environment takes the master view.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  import riscv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  imm_type_t       out_imm_type;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type, out_illegal
  );

endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extractor: instruction word -> extended immediate,
// immediate class and illegal-encoding flag.
module imm_extract
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_t       imm_type,
  output logic            illegal
);

  opcode_t     opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = opcode_t'(instr[6:0]);
  assign funct3 = instr[14:12];

  // Each format assembled at 32 bits first; the signed size cast widens to XLEN.
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    imm      = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      unique case (opcode)
        OP_LOAD, OP_JALR: begin
          imm      = XLEN'($signed(imm_i));
          imm_type = IMM_I;
        end
        OP_I_TYPE: begin
          if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
            imm      = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            imm_type = IMM_SHAMT;
          end else begin
            imm      = XLEN'($signed(imm_i));
            imm_type = IMM_I;
          end
        end
        OP_STORE: begin
          imm      = XLEN'($signed(imm_s));
          imm_type = IMM_S;
        end
        OP_BRANCH: begin
          imm      = XLEN'($signed(imm_b));
          imm_type = IMM_B;
        end
        OP_JAL: begin
          imm      = XLEN'($signed(imm_j));
          imm_type = IMM_J;
        end
        OP_LUI, OP_AUIPC: begin
          imm      = XLEN'($signed(imm_u));
          imm_type = IMM_U;
        end
        OP_SYSTEM: begin
          if (funct3[2]) begin
            imm      = XLEN'(instr[19:15]);
            imm_type = IMM_Z;
          end else begin
            imm      = XLEN'(instr[31:20]);
            imm_type = IMM_CSR;
          end
        end
        OP_R_TYPE, OP_FENCE: begin
          imm_type = IMM_NONE;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decodes on entry, holds results in a
// main register plus one skid register so in_ready never depends on out_ready.
module imm_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  imm_decode_stage_if.slave  bus
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    imm_type_t       imm_type;
    logic            illegal;
  } beat_t;

  localparam beat_t BEAT_RESET = '{
    instr: '0, pc: '0, imm: '0, imm_type: IMM_NONE, illegal: 1'b0
  };

  logic [XLEN-1:0] dec_imm;
  imm_type_t       dec_type;
  logic            dec_illegal;
  beat_t           dec_beat;

  beat_t main_q, skid_q;
  logic  main_valid, skid_valid;
  logic  accept, main_free;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr    (bus.in_instr),
    .imm      (dec_imm),
    .imm_type (dec_type),
    .illegal  (dec_illegal)
  );

  assign dec_beat = '{
    instr: bus.in_instr, pc: bus.in_pc, imm: dec_imm,
    imm_type: dec_type, illegal: dec_illegal
  };

  assign accept    = bus.in_valid && !skid_valid;
  assign main_free = !main_valid || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= BEAT_RESET;
      // NOTE: the skid payload is only ever read behind skid_valid, but it is
      // reset anyway so no X can reach the outputs through a skid->main move.
      skid_q     <= BEAT_RESET;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      // NOTE: non-blocking assignments, so skid_q read here is the pre-edge value.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= dec_beat;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec_beat;
      skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready     = !skid_valid;
  assign bus.out_valid    = main_valid;
  assign bus.out_instr    = main_q.instr;
  assign bus.out_pc       = main_q.pc;
  assign bus.out_imm      = main_q.imm;
  assign bus.out_imm_type = main_q.imm_type;
  assign bus.out_illegal  = main_q.illegal;

endmodule
